// File: rtl/dsi_multilane_dac_tx_if.sv
// Packet-word stream into the multi-lane DSI DAC transmitter.
interface dsi_multilane_dac_tx_if #(
  parameter int unsigned LANES = 2
) ();
  logic [LANES*8-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/dsi_multilane_dac_tx.sv
// Multi-lane DSI transmitter: LP-to-HS entry, LSB-first lane serialisation, trail/post,
// with every data and clock wire driven as a registered DAC code.
module dsi_multilane_dac_tx #(
  parameter int unsigned      LANES   = 2,
  parameter int unsigned      DAC_W   = 8,
  parameter int unsigned      T_LPX   = 4,
  parameter int unsigned      T_PREP  = 3,
  parameter int unsigned      T_ZERO  = 8,
  parameter int unsigned      T_TRAIL = 4,
  parameter int unsigned      T_POST  = 4,
  parameter logic [DAC_W-1:0] LP_HI   = DAC_W'(8'hFF),
  parameter logic [DAC_W-1:0] LP_LO   = DAC_W'(8'h00),
  parameter logic [DAC_W-1:0] HS_HI   = DAC_W'(8'h60),
  parameter logic [DAC_W-1:0] HS_LO   = DAC_W'(8'h40)
) (
  input  logic                   clk,
  input  logic                   rst,
  dsi_multilane_dac_tx_if.slave  src,
  output logic [LANES*DAC_W-1:0] dac_p,
  output logic [LANES*DAC_W-1:0] dac_n,
  output logic [DAC_W-1:0]       clk_dac_p,
  output logic [DAC_W-1:0]       clk_dac_n,
  output logic                   busy,
  output logic                   underrun,
  output logic                   eot
);

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_LPX, T_PREP), max2(T_ZERO, T_TRAIL)),
                                       max2(T_POST, 8));
  localparam int unsigned CW = $clog2(T_MAX + 1);
  localparam int unsigned DW = LANES * 8;
  localparam logic [7:0]  SYNC_WORD = 8'hB8;

  typedef enum logic [2:0] {IDLE, LP01, LP00, HS_ZERO, SYNC, DATA, TRAIL, POST} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DW-1:0]            sh_q, sh_d;
  logic                     last_q, last_d;
  logic [LANES-1:0]         lbit_q, lbit_d;
  logic                     ph_q, ph_d;
  logic                     ready_q, ready_d;
  logic                     ur_d, eot_d, busy_d;
  logic [LANES*DAC_W-1:0]   dp_d, dn_d;
  logic [DAC_W-1:0]         cp_d, cn_d;

  assign src.s_ready = ready_q;

  // State, timing counter, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      last_q    <= 1'b0;
      lbit_q    <= '0;
      ph_q      <= 1'b0;
      ready_q   <= 1'b0;
      underrun  <= 1'b0;
      eot       <= 1'b0;
      busy      <= 1'b0;
      dac_p     <= {LANES{LP_HI}};
      dac_n     <= {LANES{LP_HI}};
      clk_dac_p <= LP_HI;
      clk_dac_n <= LP_HI;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      last_q    <= last_d;
      lbit_q    <= lbit_d;
      ph_q      <= ph_d;
      ready_q   <= ready_d;
      underrun  <= ur_d;
      eot       <= eot_d;
      busy      <= busy_d;
      dac_p     <= dp_d;
      dac_n     <= dn_d;
      clk_dac_p <= cp_d;
      clk_dac_n <= cn_d;
    end
  end

  // Next state plus the codes for the cycle that state will occupy.
  always_comb begin
    logic          acc;
    logic [CW-1:0] cnt_dec;
    logic [2:0]    bidx;
    logic          lb;

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    last_d  = last_q;
    lbit_d  = lbit_q;
    ph_d    = ~ph_q;
    ur_d    = 1'b0;
    eot_d   = 1'b0;
    dp_d    = {LANES{LP_HI}};
    dn_d    = {LANES{LP_HI}};
    cp_d    = LP_HI;
    cn_d    = LP_HI;
    acc     = ready_q & src.s_valid;
    cnt_dec = cnt_q - CW'(1);
    bidx    = 3'd0;
    lb      = 1'b0;

    unique case (state_q)
      // In IDLE the counter is the LP-11 hold timer; it saturates at zero.
      IDLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else if (src.s_valid) begin
          state_d = LP01;
          cnt_d   = CW'(T_LPX - 1);
        end
      end
      LP01: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          state_d = LP00;
          cnt_d   = CW'(T_PREP - 1);
        end
      end
      LP00: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          state_d = HS_ZERO;
          cnt_d   = CW'(T_ZERO - 1);
          ph_d    = 1'b1;
        end
      end
      HS_ZERO: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          state_d = SYNC;
          cnt_d   = CW'(7);
        end
      end
      SYNC, DATA: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          if (state_q == DATA && last_q) begin
            state_d = TRAIL;
            cnt_d   = CW'(T_TRAIL - 1);
          end else if (acc) begin
            state_d = DATA;
            cnt_d   = CW'(7);
            sh_d    = src.s_data;
            last_d  = src.s_last;
          end else begin
            state_d = TRAIL;
            cnt_d   = CW'(T_TRAIL - 1);
            ur_d    = 1'b1;
          end
        end
      end
      TRAIL: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          state_d = POST;
          cnt_d   = CW'(T_POST - 1);
        end
      end
      POST: begin
        cnt_d = cnt_dec;
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = CW'(T_LPX - 1);
          eot_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    bidx = ~3'(cnt_d);
    for (int unsigned k = 0; k < LANES; k++) begin
      lb = (state_d == SYNC) ? SYNC_WORD[bidx] : sh_d[k*8 + 32'(bidx)];
      if (state_d == SYNC || state_d == DATA) lbit_d[k] = lb;
      unique case (state_d)
        LP01:       begin dp_d[k*DAC_W +: DAC_W] = LP_LO; dn_d[k*DAC_W +: DAC_W] = LP_HI; end
        LP00:       begin dp_d[k*DAC_W +: DAC_W] = LP_LO; dn_d[k*DAC_W +: DAC_W] = LP_LO; end
        HS_ZERO:    begin dp_d[k*DAC_W +: DAC_W] = HS_LO; dn_d[k*DAC_W +: DAC_W] = HS_HI; end
        SYNC, DATA: begin
          dp_d[k*DAC_W +: DAC_W] = lb ? HS_HI : HS_LO;
          dn_d[k*DAC_W +: DAC_W] = lb ? HS_LO : HS_HI;
        end
        TRAIL:      begin
          dp_d[k*DAC_W +: DAC_W] = lbit_d[k] ? HS_LO : HS_HI;
          dn_d[k*DAC_W +: DAC_W] = lbit_d[k] ? HS_HI : HS_LO;
        end
        default:    begin dp_d[k*DAC_W +: DAC_W] = LP_HI; dn_d[k*DAC_W +: DAC_W] = LP_HI; end
      endcase
    end

    unique case (state_d)
      IDLE:    begin cp_d = LP_HI; cn_d = LP_HI; end
      LP01:    begin cp_d = LP_LO; cn_d = LP_HI; end
      LP00:    begin cp_d = LP_LO; cn_d = LP_LO; end
      default: begin cp_d = ph_d ? HS_HI : HS_LO; cn_d = ph_d ? HS_LO : HS_HI; end
    endcase

    ready_d = (cnt_d == '0) && ((state_d == SYNC) || (state_d == DATA && !last_d));
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_dsi_multilane_dac_tx.sv
// Directed bench for dsi_multilane_dac_tx: LANES=1/2/4 builds side by side.
module tb_dsi_multilane_dac_tx;

  localparam logic [15:0] S_LP11 = 16'hFFFF;  // {P,N}
  localparam logic [15:0] S_LP01 = 16'h00FF;
  localparam logic [15:0] S_LP00 = 16'h0000;
  localparam logic [15:0] S_HS1  = 16'h6040;
  localparam logic [15:0] S_HS0  = 16'h4060;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsi_multilane_dac_tx_if #(.LANES(1)) bus1 ();
  dsi_multilane_dac_tx_if #(.LANES(2)) bus2 ();
  dsi_multilane_dac_tx_if #(.LANES(4)) bus4 ();

  logic [7:0]  dp1, dn1;
  logic [15:0] dp2, dn2;
  logic [31:0] dp4, dn4;
  logic [7:0]  cp1, cn1, cp2, cn2, cp4, cn4;
  logic        busy1, ur1, eot1, busy2, ur2, eot2, busy4, ur4, eot4;

  dsi_multilane_dac_tx #(.LANES(1)) u1 (.clk(clk), .rst(rst), .src(bus1), .dac_p(dp1), .dac_n(dn1),
    .clk_dac_p(cp1), .clk_dac_n(cn1), .busy(busy1), .underrun(ur1), .eot(eot1));
  dsi_multilane_dac_tx #(.LANES(2)) u2 (.clk(clk), .rst(rst), .src(bus2), .dac_p(dp2), .dac_n(dn2),
    .clk_dac_p(cp2), .clk_dac_n(cn2), .busy(busy2), .underrun(ur2), .eot(eot2));
  dsi_multilane_dac_tx #(.LANES(4)) u4 (.clk(clk), .rst(rst), .src(bus4), .dac_p(dp4), .dac_n(dn4),
    .clk_dac_p(cp4), .clk_dac_n(cn4), .busy(busy4), .underrun(ur4), .eot(eot4));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {P,N} of a data lane in a single-word burst; cycle 1 is the first LP01 cycle.
  function automatic logic [15:0] lane_exp(int c, logic [7:0] b);
    logic [7:0] sy;
    sy = 8'hB8;
    if (c >= 1 && c <= 4)   return S_LP01;
    if (c >= 5 && c <= 7)   return S_LP00;
    if (c >= 8 && c <= 15)  return S_HS0;
    if (c >= 16 && c <= 23) return sy[c-16] ? S_HS1 : S_HS0;
    if (c >= 24 && c <= 31) return b[c-24] ? S_HS1 : S_HS0;
    if (c >= 32 && c <= 35) return b[7] ? S_HS0 : S_HS1;
    return S_LP11;
  endfunction

  function automatic logic [15:0] clk_exp(int c, int last_hs);
    if (c >= 1 && c <= 4)       return S_LP01;
    if (c >= 5 && c <= 7)       return S_LP00;
    if (c >= 8 && c <= last_hs) return ((c - 8) % 2 == 0) ? S_HS1 : S_HS0;
    return S_LP11;
  endfunction

  initial begin
    logic [7:0]  w1;
    logic [15:0] w2;
    logic [31:0] w4;
    logic [15:0] words [4];
    logic        lastf [4];
    int idx, nrdy, e1, e2, lp2, urn, urc;
    int rdyc [8];

    bus1.s_valid = 1'b0; bus1.s_last = 1'b0; bus1.s_data = '0;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0; bus2.s_data = '0;
    bus4.s_valid = 1'b0; bus4.s_last = 1'b0; bus4.s_data = '0;

    // Reset values
    @(negedge clk);
    chk("rst_dac2", {dp2, dn2, cp2, cn2}, {48{1'b1}});
    chk("rst_dac4", {dp4, dn4}, {64{1'b1}});
    chk("rst_ctl2", {busy2, bus2.s_ready, ur2, eot2}, 4'b0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ctl2", {busy2, bus2.s_ready, eot2}, 3'b000);
    chk("idle_dac2", {dp2, dn2, cp2, cn2}, {48{1'b1}});

    // Single-word burst on all three builds in lock-step
    w1 = 8'h96; w2 = 16'hA53C; w4 = 32'h12F0813C;
    bus1.s_data = w1; bus2.s_data = w2; bus4.s_data = w4;
    bus1.s_last = 1'b1; bus2.s_last = 1'b1; bus4.s_last = 1'b1;
    bus1.s_valid = 1'b1; bus2.s_valid = 1'b1; bus4.s_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk($sformatf("sw1_l0_c%0d", c), {dp1, dn1}, lane_exp(c, w1));
      for (int k = 0; k < 2; k++)
        chk($sformatf("sw2_l%0d_c%0d", k, c), {dp2[k*8 +: 8], dn2[k*8 +: 8]}, lane_exp(c, w2[k*8 +: 8]));
      for (int k = 0; k < 4; k++)
        chk($sformatf("sw4_l%0d_c%0d", k, c), {dp4[k*8 +: 8], dn4[k*8 +: 8]}, lane_exp(c, w4[k*8 +: 8]));
      chk($sformatf("sw2_clk_c%0d", c), {cp2, cn2}, clk_exp(c, 39));
      chk($sformatf("sw4_clk_c%0d", c), {cp4, cn4}, clk_exp(c, 39));
      chk($sformatf("sw1_ctl_c%0d", c), {busy1, bus1.s_ready, ur1, eot1}, {c <= 39, c == 23, 1'b0, c == 40});
      chk($sformatf("sw2_ctl_c%0d", c), {busy2, bus2.s_ready, ur2, eot2}, {c <= 39, c == 23, 1'b0, c == 40});
      chk($sformatf("sw4_ctl_c%0d", c), {busy4, bus4.s_ready, ur4, eot4}, {c <= 39, c == 23, 1'b0, c == 40});
      if (c == 24) begin
        bus1.s_valid = 1'b0; bus2.s_valid = 1'b0; bus4.s_valid = 1'b0;
      end
    end
    repeat (6) @(negedge clk);

    // Three-word packet with s_valid held, then back-to-back single word
    words[0] = 16'h5AC3; words[1] = 16'h0FC3; words[2] = 16'hE724; words[3] = 16'h3C99;
    lastf[0] = 1'b0; lastf[1] = 1'b0; lastf[2] = 1'b1; lastf[3] = 1'b1;
    w1 = words[1][7:0];
    idx = 0; nrdy = 0; e1 = -1; e2 = -1; lp2 = -1; urn = 0;
    foreach (rdyc[i]) rdyc[i] = -1;
    bus2.s_data = words[0]; bus2.s_last = lastf[0]; bus2.s_valid = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (bus2.s_ready) begin
        if (nrdy < 8) rdyc[nrdy] = c;
        nrdy++;
      end
      if (ur2) urn++;
      if (c >= 8 && c <= 55) chk($sformatf("mw_clk_c%0d", c), {cp2, cn2}, ((c - 8) % 2 == 0) ? S_HS1 : S_HS0);
      if (c >= 32 && c <= 39) chk($sformatf("mw_w1_c%0d", c), {dp2[7:0], dn2[7:0]}, w1[c-32] ? S_HS1 : S_HS0);
      if (eot2 && e1 >= 0 && e2 < 0) e2 = c;
      if (eot2 && e1 < 0) e1 = c;
      if (e1 >= 0 && e2 < 0 && busy2 && lp2 < 0) begin
        lp2 = c;
        chk("b2b_lp01", {dp2[7:0], dn2[7:0], cp2, cn2}, {S_LP01, S_LP01});
      end
      if (idx < 4) begin
        bus2.s_data = words[idx]; bus2.s_last = lastf[idx]; bus2.s_valid = 1'b1;
        if (bus2.s_ready) idx++;
      end else begin
        bus2.s_valid = 1'b0;
      end
      if (e2 >= 0) break;
    end
    chk("mw_nrdy", 32'(nrdy), 32'd4);
    chk("mw_rdy0", 32'(rdyc[0]), 32'd23);
    chk("mw_rdy1", 32'(rdyc[1]), 32'd31);
    chk("mw_rdy2", 32'(rdyc[2]), 32'd39);
    chk("mw_eot",  32'(e1), 32'd56);
    chk("b2b_lp01_cycle", 32'(lp2), 32'd60);
    chk("b2b_rdy", 32'(rdyc[3]), 32'd82);
    chk("b2b_eot", 32'(e2), 32'd99);
    chk("mw_no_ur", 32'(urn), 32'd0);
    repeat (6) @(negedge clk);

    // Underrun at the second word boundary
    w2 = 16'h7E18;
    nrdy = 0; urn = 0; urc = -1; e1 = -1;
    foreach (rdyc[i]) rdyc[i] = -1;
    bus2.s_data = w2; bus2.s_last = 1'b0; bus2.s_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ur2) begin
        urn++;
        if (urc < 0) urc = c;
      end
      if (c >= 32 && c <= 35) begin
        chk($sformatf("ur_trail0_c%0d", c), {dp2[7:0], dn2[7:0]}, S_HS1);
        chk($sformatf("ur_trail1_c%0d", c), {dp2[15:8], dn2[15:8]}, S_HS1);
      end
      if (c >= 36 && c <= 39) chk($sformatf("ur_post_c%0d", c), {dp2, dn2}, 32'hFFFFFFFF);
      if (eot2 && e1 < 0) e1 = c;
      if (bus2.s_ready) begin
        if (nrdy < 8) rdyc[nrdy] = c;
        nrdy++;
        if (nrdy == 1) bus2.s_valid = 1'b1;
      end
      if (nrdy >= 1 && !(bus2.s_ready && nrdy == 1)) bus2.s_valid = 1'b0;
      if (e1 >= 0) break;
    end
    chk("ur_nrdy", 32'(nrdy), 32'd2);
    chk("ur_rdy1", 32'(rdyc[1]), 32'd31);
    chk("ur_pulse_cycle", 32'(urc), 32'd32);
    chk("ur_pulse_count", 32'(urn), 32'd1);
    chk("ur_eot", 32'(e1), 32'd40);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-burst, then immediate restart
    bus2.s_data = 16'hA53C; bus2.s_last = 1'b1; bus2.s_valid = 1'b1;
    repeat (28) @(negedge clk);
    chk("mid_busy", {28'd0, busy2}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dac2", {dp2, dn2, cp2, cn2}, {48{1'b1}});
    chk("mid_rst_ctl2", {busy2, bus2.s_ready, ur2, eot2}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_lp01", {dp2[7:0], dn2[7:0], cp2, cn2}, {S_LP01, S_LP01});
    chk("restart_busy", {31'd0, busy2}, 32'd1);
    bus2.s_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsi_multilane_dac_tx.md
Name: dsi_multilane_dac_tx

Overview:
Parametrised multi-lane successor to the single-lane DSI protocol/slave pair. It accepts a packet as a stream of LANES-byte words and runs the full LP-to-HS entry sequence. It serialises the bytes over LANES data lanes plus one clock lane and then returns to LP-11. Each wire is emitted as a DAC code, so the block drives the board's video DACs directly and sits between the packet source and the DAC pins.

Parameters:
LANES, 2, number of data lanes (1..4)
DAC_W, 8, DAC code width
T_LPX, 4, cycles in LP-01, and minimum LP-11 hold between bursts
T_PREP, 3, cycles in LP-00
T_ZERO, 8, cycles of HS-0 before sync
T_TRAIL, 4, cycles of trail
T_POST, 4, clock-lane HS cycles after data trail
LP_HI, 8'hFF, LP high code
LP_LO, 8'h00, LP low code
HS_HI, 8'h60, HS high code
HS_LO, 8'h40, HS low code

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  reset, asynchronous, active-low
s_data  in  LANES*8  packet word; byte k goes to lane k
s_valid  in  1  word valid
s_last  in  1  word is last of packet
s_ready  out  1  word accepted this cycle (s_valid & s_ready)
dac_p  out  LANES*DAC_W  per-lane P-wire code; lane k at [k*DAC_W +: DAC_W]
dac_n  out  LANES*DAC_W  per-lane N-wire code
clk_dac_p  out  DAC_W  clock lane P code
clk_dac_n  out  DAC_W  clock lane N code
busy  out  1  high in every state except IDLE
underrun  out  1  one-cycle pulse when a word is missing mid-packet
eot  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-low.
- Reset, including reset mid-burst: asynchronous jump to IDLE with hold counter saturated, so a new burst is allowed immediately.
  - Output values under reset: all dac_p, dac_n, clk_dac_p and clk_dac_n = LP_HI; s_ready=0; busy=0; underrun=0; eot=0.
- Line codes:
  - LP11: P=LP_HI, N=LP_HI.
  - LP01: P=LP_LO, N=LP_HI.
  - LP00: P=LP_LO, N=LP_LO.
  - HS1: P=HS_HI, N=HS_LO.
  - HS0: P=HS_LO, N=HS_HI.
- FSM states: IDLE, LP01, LP00, HS_ZERO, SYNC, DATA, TRAIL, POST.
  - A single down-counter times each state; all outputs are registered.
- IDLE:
  - Data and clock lanes drive LP11.
  - Go to LP01 when s_valid=1 and IDLE has lasted at least T_LPX cycles.
- LP01 (T_LPX cycles) then LP00 (T_PREP cycles):
  - Same code on all data lanes and on the clock lane.
- HS_ZERO (T_ZERO cycles):
  - Data lanes drive HS0.
  - Clock lane starts toggling, HS1 first, inverting every cycle from here through POST.
- SYNC (8 cycles):
  - Every lane sends 0xB8, LSB first, one bit per cycle.
  - s_ready=1 on the 8th SYNC cycle.
  - If s_valid=0 on that cycle: underrun pulse, go to TRAIL.
- DATA:
  - Each lane shifts its captured byte LSB first, 8 cycles per word.
  - s_ready=1 on bit-7 cycle of each word, unless the current word had s_last.
  - After bit 7 of the last word, go to TRAIL.
  - If s_ready=1 and s_valid=0 on a word boundary: underrun pulse, go to TRAIL; the packet is truncated.
- TRAIL (T_TRAIL cycles):
  - Each data lane drives the inverse of its own last transmitted bit.
- POST (T_POST cycles):
  - Data lanes drive LP11; clock lane keeps toggling.
  - Then IDLE, with eot=1 on the first IDLE cycle.
- s_ready is asserted only in the cases above.
  - It never depends combinationally on s_valid.
  - s_last is sampled only with an accepted word.
- Inputs are ignored outside the acceptance cycles.
  - s_valid high in TRAIL or POST queues nothing; the next burst starts from IDLE.
- Counter widths: ceil(log2(max(T_*,8)+1)).
  - All T_* parameters must be at least 1.

Test Plan:
- Reset: assert rst=0 mid-run -> all DAC outputs 8'hFF same cycle; busy=0; s_ready=0.
- Single word, LANES=2, s_data=16'hA5_3C, s_last=1, s_valid raised at IDLE:
  - Phase lengths: LP01 4, LP00 3, HS0 8, SYNC 8.
  - s_ready high exactly on cycle 23 after LP01 entry.
  - Lane0 bits 0,0,1,1,1,1,0,0; lane1 bits 1,0,1,0,0,1,0,1.
  - Trail: lane0 drives HS1, lane1 drives HS0, for 4 cycles.
  - POST 4, then eot; 39 busy cycles total.
- Three-word packet, s_valid held high:
  - s_ready pulses spaced exactly 8 cycles apart, two pulses total after SYNC.
  - Clock lane toggles continuously from HS_ZERO to end of POST.
- Underrun: drop s_valid before 2nd word boundary -> underrun pulse on that boundary; TRAIL follows immediately; eot still issued.
- Back-to-back: s_valid held high after eot -> IDLE lasts exactly 4 cycles before LP01.
- LANES=1 and LANES=4 builds: byte mapping per lane correct; unused patterns not generated.
